pixel_packer: RTL and testbench

Downstream stage of the pixel XOR path. Accepts the 8-bit pixel stream one pixel per cycle and packs three pixels into a 24-bit word. Buffers packed words in a small FIFO and presents them on a valid/ready interface to the 24-bit memory/DSP write side. Raises a back-pressure request toward the pixel source and flags overruns.

---
 rtl/pixel_packer.sv | 129 ++++++++++++
 tb/tb_pixel_packer.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/pixel_packer.sv
// pixel_packer: packs three 8-bit pixels into a 24-bit word and buffers words in a DEPTH-entry FIFO.
// Define PIXEL_PACKER_WCNT_EN to add the 16-bit delivered-word counter output wcnt.
module pixel_packer #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rstn,
  input  logic [7:0]  pixel_in,
  input  logic        pixel_valid,
  output logic        pix_req,
  input  logic        flush,
  output logic [23:0] word_out,
  output logic        word_valid,
  input  logic        word_ready,
  output logic        ovf
`ifdef PIXEL_PACKER_WCNT_EN
  ,
  output logic [15:0] wcnt
`endif
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW:0] FULL = (AW+1)'(DEPTH);
  localparam logic [AW:0] ONE  = (AW+1)'(1);

  logic [1:0]    lane;
  logic [23:0]   pack;
  logic [23:0]   mem [DEPTH];
  logic [AW-1:0] wr_ptr;
  logic [AW-1:0] rd_ptr;
  logic [AW-1:0] rd_ptr_nxt;
  logic [AW:0]   fifo_count;
  logic          alive;
  logic          accept;
  logic          flush_eff;
  logic          push;
  logic          pop;
  logic [23:0]   pack_with_pixel;
  logic [23:0]   push_data;

  // alive keeps pix_req low after reset release until the first clock edge
  assign pix_req    = !rstn && alive && (fifo_count != FULL);
  assign word_valid = (fifo_count != '0);
  assign accept     = pixel_valid && pix_req;
  assign flush_eff  = flush && pix_req;
  assign pop        = word_valid && word_ready;
  assign rd_ptr_nxt = rd_ptr + 1'b1;

  always_comb begin
    pack_with_pixel = pack;
    case (lane)
      2'd0:    pack_with_pixel[7:0]   = pixel_in;
      2'd1:    pack_with_pixel[15:8]  = pixel_in;
      default: pack_with_pixel[23:16] = pixel_in;
    endcase
  end

  // A flush that coincides with the completing pixel still yields a single push
  assign push_data = accept ? pack_with_pixel : pack;
  assign push      = (accept && (lane == 2'd2)) ||
                     (flush_eff && ((lane != 2'd0) || accept));

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      lane  <= 2'd0;
      pack  <= 24'd0;
      alive <= 1'b0;
      ovf   <= 1'b0;
    end else begin
      alive <= 1'b1;
      if (push) begin
        lane <= 2'd0;
        pack <= 24'd0;
      end else if (accept) begin
        lane <= lane + 2'd1;
        pack <= pack_with_pixel;
      end
      if (pixel_valid && !pix_req)
        ovf <= 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push)
      mem[wr_ptr] <= push_data;
  end

  // word_out is the registered FIFO head; on a pop it moves to the next entry
  always_ff @(posedge clk or posedge rstn) begin
    if (rstn) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
      word_out   <= 24'd0;
    end else begin
      if (push)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop)
        rd_ptr <= rd_ptr_nxt;
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + ONE;
        2'b01:   fifo_count <= fifo_count - ONE;
        default: fifo_count <= fifo_count;
      endcase
      if (pop) begin
        if (fifo_count > ONE)
          word_out <= mem[rd_ptr_nxt];
        else if (push)
          word_out <= push_data;
      end else if (push && (fifo_count == '0)) begin
        word_out <= push_data;
      end
    end
  end

`ifdef PIXEL_PACKER_WCNT_EN
  logic [15:0] wcnt_q;

  always_ff @(posedge clk or posedge rstn) begin
    if (rstn)
      wcnt_q <= 16'd0;
    else if (pop)
      wcnt_q <= wcnt_q + 16'd1;
  end

  assign wcnt = wcnt_q;
`endif

endmodule

// File: tb/tb_pixel_packer.sv
// tb_pixel_packer: directed and random stimulus for pixel_packer, checked against a queue-based model.
module tb_pixel_packer;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rstn;
  logic [7:0]  pixel_in;
  logic        pixel_valid;
  logic        pix_req;
  logic        flush;
  logic [23:0] word_out;
  logic        word_valid;
  logic        word_ready;
  logic        ovf;
`ifdef PIXEL_PACKER_WCNT_EN
  logic [15:0] wcnt;
`endif

  pixel_packer #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rstn        (rstn),
    .pixel_in    (pixel_in),
    .pixel_valid (pixel_valid),
    .pix_req     (pix_req),
    .flush       (flush),
    .word_out    (word_out),
    .word_valid  (word_valid),
    .word_ready  (word_ready),
    .ovf         (ovf)
`ifdef PIXEL_PACKER_WCNT_EN
    ,
    .wcnt        (wcnt)
`endif
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: bytes of the open word, queue of buffered words, sticky flags
  logic [7:0]  m_partial[$];
  logic [23:0] m_words[$];
  bit          m_alive;
  bit          m_ovf;
  logic [15:0] m_wcnt;

  task automatic check_output(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h expected=%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  function automatic bit model_req();
    return m_alive && (m_words.size() != DEPTH);
  endfunction

  task automatic model_reset();
    m_partial.delete();
    m_words.delete();
    m_alive = 1'b0;
    m_ovf   = 1'b0;
    m_wcnt  = 16'd0;
  endtask

  task automatic check_state(input string tag);
    check_output({tag, ".pix_req"}, 32'(pix_req), 32'(model_req()));
    check_output({tag, ".word_valid"}, 32'(word_valid), 32'(m_words.size() != 0));
    check_output({tag, ".ovf"}, 32'(ovf), 32'(m_ovf));
    if (m_words.size() != 0)
      check_output({tag, ".word_out"}, 32'(word_out), 32'(m_words[0]));
`ifdef PIXEL_PACKER_WCNT_EN
    check_output({tag, ".wcnt"}, 32'(wcnt), 32'(m_wcnt));
`endif
  endtask

  // One clock cycle: drive inputs, check outputs, advance model across the edge
  task automatic apply_stimulus(input bit v, input logic [7:0] pix, input bit fl, input bit rdy);
    bit          req;
    bit          acc;
    bit          fe;
    bit          pp;
    logic [23:0] w;
    pixel_valid = v;
    pixel_in    = pix;
    flush       = fl;
    word_ready  = rdy;
    check_state("cyc");
    req = model_req();
    acc = v && req;
    fe  = fl && req;
    pp  = (m_words.size() != 0) && rdy;
    @(posedge clk);
    if (v && !req)
      m_ovf = 1'b1;
    if (pp) begin
      void'(m_words.pop_front());
      m_wcnt = m_wcnt + 16'd1;
    end
    if (acc)
      m_partial.push_back(pix);
    if ((m_partial.size() == 3) || (fe && (m_partial.size() != 0))) begin
      w = 24'd0;
      foreach (m_partial[i])
        w = w | (24'(m_partial[i]) << (8 * i));
      m_words.push_back(w);
      m_partial.delete();
    end
    m_alive = 1'b1;
    @(negedge clk);
  endtask

  task automatic reset_dut();
    rstn = 1'b1;
    #1;
    check_output("rst.word_valid", 32'(word_valid), 32'd0);
    check_output("rst.ovf", 32'(ovf), 32'd0);
    check_output("rst.pix_req", 32'(pix_req), 32'd0);
    check_output("rst.word_out", 32'(word_out), 32'd0);
`ifdef PIXEL_PACKER_WCNT_EN
    check_output("rst.wcnt", 32'(wcnt), 32'd0);
`endif
    model_reset();
    repeat (2) @(negedge clk);
    rstn = 1'b0;
    #1;
    check_output("rel.pix_req", 32'(pix_req), 32'd0);
  endtask

  initial begin
    pixel_valid = 1'b0;
    pixel_in    = 8'd0;
    flush       = 1'b0;
    word_ready  = 1'b0;
    @(negedge clk);
    reset_dut();
    apply_stimulus(0, 8'h00, 0, 1);

    apply_stimulus(1, 8'h11, 0, 1);
    apply_stimulus(1, 8'h22, 0, 1);
    apply_stimulus(1, 8'h33, 0, 1);
    check_output("plan1.valid", 32'(word_valid), 32'd1);
    check_output("plan1.word", 32'(word_out), 32'h332211);
    apply_stimulus(0, 8'h00, 0, 1);
    check_output("plan1.one_cycle", 32'(word_valid), 32'd0);

    apply_stimulus(1, 8'hAA, 0, 0);
    apply_stimulus(1, 8'hBB, 0, 0);
    apply_stimulus(0, 8'h00, 1, 0);
    check_output("plan2.flush_word", 32'(word_out), 32'h00BBAA);
    apply_stimulus(1, 8'h01, 0, 1);
    apply_stimulus(1, 8'h02, 0, 1);
    apply_stimulus(1, 8'h03, 0, 1);
    check_output("plan2.no_stale", 32'(word_out), 32'h030201);
    apply_stimulus(0, 8'h00, 0, 1);

    apply_stimulus(1, 8'h5A, 0, 0);
    apply_stimulus(1, 8'h5B, 0, 0);
    apply_stimulus(1, 8'h5C, 1, 0);
    check_output("plan4.word", 32'(word_out), 32'h5C5B5A);
    apply_stimulus(0, 8'h00, 0, 1);
    check_output("plan4.single_push", 32'(word_valid), 32'd0);

    for (int i = 0; i < 12; i++)
      apply_stimulus(1, 8'(8'h80 + i), 0, 0);
    check_output("plan3.full_req", 32'(pix_req), 32'd0);
    apply_stimulus(1, 8'hEE, 0, 0);
    check_output("plan3.ovf", 32'(ovf), 32'd1);
    check_output("plan3.head", 32'(word_out), 32'h828180);
    for (int i = 0; i < 5; i++)
      apply_stimulus(0, 8'h00, 0, 1);
    check_output("plan3.ovf_sticky", 32'(ovf), 32'd1);

    for (int i = 0; i < 7; i++)
      apply_stimulus(1, 8'(8'h40 + i), 0, 0);
    #2;
    reset_dut();
    apply_stimulus(0, 8'h00, 0, 1);
    apply_stimulus(1, 8'h61, 0, 0);
    apply_stimulus(1, 8'h62, 0, 0);
    apply_stimulus(1, 8'h63, 0, 0);
    check_output("plan5.fresh", 32'(word_out), 32'h636261);
    apply_stimulus(0, 8'h00, 0, 1);

`ifdef PIXEL_PACKER_WCNT_EN
    force dut.wcnt_q = 16'hFFFF;
    #1;
    release dut.wcnt_q;
    m_wcnt = 16'hFFFF;
    apply_stimulus(1, 8'h71, 0, 0);
    apply_stimulus(1, 8'h72, 0, 0);
    apply_stimulus(1, 8'h73, 0, 0);
    apply_stimulus(0, 8'h00, 0, 1);
    check_output("wcnt.wrap", 32'(wcnt), 32'h0000);
`endif

    // Random phase with varying consumer pressure to exercise full and empty FIFO
    for (int blk = 0; blk < 15; blk++) begin
      int rdy_pct;
      rdy_pct = $urandom_range(10, 95);
      for (int i = 0; i < 200; i++)
        apply_stimulus(($urandom_range(0, 99) < 75), 8'($urandom),
                       ($urandom_range(0, 99) < 10),
                       ($urandom_range(0, 99) < rdy_pct));
    end
    for (int i = 0; i < DEPTH + 2; i++)
      apply_stimulus(0, 8'h00, 0, 1);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
